// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding, default field
// widths, reserved note codes and the busy-state decode.
package song_pkg;

  localparam int SONG_NOTE_W = 7;
  localparam int SONG_DUR_W  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4,
    PAUSE = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [SONG_NOTE_W-1:0] NOTE_REST = {SONG_NOTE_W{1'b0}};
  localparam logic [SONG_NOTE_W-1:0] NOTE_END  = {SONG_NOTE_W{1'b1}};

  // States in which the sequencer owns the ROM and the tone output
  function automatic logic is_busy_state(input state_e s);
    case (s)
      FETCH, LOAD, PLAY, GAP, PAUSE: is_busy_state = 1'b1;
      default:                       is_busy_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/song_beat_tick_gen.sv
// Beat prescaler: emits a one-cycle tick every max(tempo_div,1) enabled cycles.
// Holding en low freezes the count; clr restarts it from zero.
module beat_tick_gen #(
  parameter int TEMPO_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  input  logic [TEMPO_W-1:0] tempo_div,
  output logic               tick
);

  logic [TEMPO_W-1:0] cnt_r;
  logic [TEMPO_W-1:0] last_s;
  logic               hit_s;

  // Compare against the live divider so tempo changes apply at the next compare
  always_comb begin
    if (tempo_div == {TEMPO_W{1'b0}}) begin
      last_s = {TEMPO_W{1'b0}};
    end else begin
      last_s = tempo_div - TEMPO_W'(1'b1);
    end
    // >= so a divider shrunk below the running count ticks at once
    hit_s = (cnt_r >= last_s);
    tick  = en & hit_s;
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {TEMPO_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TEMPO_W{1'b0}};
    end else if (en) begin
      if (hit_s) begin
        cnt_r <= {TEMPO_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + TEMPO_W'(1'b1);
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Note-ROM playback controller with play/pause/stop, beat timing and inter-note gap.
// Define SONG_LOOP_EN to restart from address 0 at end of song instead of halting.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NOTE_W  = SONG_NOTE_W,
  parameter int DUR_W   = SONG_DUR_W,
  parameter int ADDR_W  = 6,
  parameter int TEMPO_W = 32,
  parameter int GAP_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic                    pause,
  input  logic                    stop,
  input  logic [TEMPO_W-1:0]      tempo_div,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    busy,
  output logic                    done
);

  localparam int                GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [NOTE_W-1:0] END_CODE  = {NOTE_W{NOTE_END[0]}};
  localparam logic [NOTE_W-1:0] REST_CODE = {NOTE_W{NOTE_REST[0]}};

  state_e              state_r, state_s;
  state_e              saved_r, saved_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [NOTE_W-1:0]   note_r, note_s;
  logic [NOTE_W-1:0]   cur_note_r, cur_note_s;
  logic [DUR_W-1:0]    beat_r, beat_s;
  logic [GAP_W-1:0]    gap_r, gap_s;
  logic                busy_r;
  logic                done_r, done_s;
  logic                advance_s, finish_s;
  logic                tick_s, tick_en_s, tick_clr_s;
  logic [NOTE_W-1:0]   note_field_s;
  logic [DUR_W-1:0]    dur_field_s;

  assign note_field_s = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign dur_field_s  = rom_data[DUR_W-1:0];

  // The prescaler only runs in an uninterrupted PLAY cycle
  assign tick_en_s  = (state_r == PLAY) && !stop && !pause;
  assign tick_clr_s = stop || (state_r == LOAD);

  beat_tick_gen #(
    .TEMPO_W (TEMPO_W)
  ) u_beat_tick_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (tick_en_s),
    .clr       (tick_clr_s),
    .tempo_div (tempo_div),
    .tick      (tick_s)
  );

  // Next-state, address, note and counter logic; stop outranks pause outranks play
  always_comb begin
    state_s    = state_r;
    saved_s    = saved_r;
    addr_s     = addr_r;
    note_s     = note_r;
    cur_note_s = cur_note_r;
    beat_s     = beat_r;
    gap_s      = gap_r;
    done_s     = 1'b0;
    advance_s  = 1'b0;
    finish_s   = 1'b0;
    if (stop) begin
      state_s = IDLE;
      addr_s  = {ADDR_W{1'b0}};
      note_s  = REST_CODE;
      beat_s  = {DUR_W{1'b0}};
      gap_s   = {GAP_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (play) begin
            state_s = FETCH;
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: state_s = LOAD;
        LOAD: begin
          if (note_field_s == END_CODE) begin
            finish_s = 1'b1;
          end else begin
            cur_note_s = note_field_s;
            note_s     = note_field_s;
            beat_s     = dur_field_s;
            state_s    = PLAY;
          end
        end
        PLAY: begin
          if (pause) begin
            saved_s = PLAY;
            state_s = PAUSE;
            note_s  = REST_CODE;
          end else if (!tick_s) begin
            beat_s = beat_r;
          end else if (beat_r != {DUR_W{1'b0}}) begin
            beat_s = beat_r - DUR_W'(1'b1);
          end else begin
            note_s = REST_CODE;
            gap_s  = {GAP_W{1'b0}};
            if (GAP_CYC == 0) begin
              advance_s = 1'b1;
            end else begin
              state_s = GAP;
            end
          end
        end
        GAP: begin
          if (pause) begin
            saved_s = GAP;
            state_s = PAUSE;
          end else if (gap_r == GAP_LAST) begin
            advance_s = 1'b1;
          end else begin
            gap_s = gap_r + GAP_W'(1'b1);
          end
        end
        PAUSE: begin
          if (pause) begin
            state_s = PAUSE;
          end else if (play) begin
            state_s = saved_r;
            if (saved_r == PLAY) begin
              note_s = cur_note_r;
            end else begin
              note_s = REST_CODE;
            end
          end else begin
            state_s = PAUSE;
          end
        end
        DONE: begin
          note_s = REST_CODE;
          addr_s = {ADDR_W{1'b0}};
          if (play) begin
            state_s = FETCH;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
          addr_s  = {ADDR_W{1'b0}};
          note_s  = REST_CODE;
        end
      endcase
      // Completing the last addressable note counts as reaching the end marker
      if (finish_s || (advance_s && (addr_r == ADDR_LAST))) begin
        done_s = 1'b1;
        addr_s = {ADDR_W{1'b0}};
        note_s = REST_CODE;
`ifdef SONG_LOOP_EN
        state_s = FETCH;
`else
        state_s = DONE;
`endif
      end else if (advance_s) begin
        addr_s  = addr_r + ADDR_W'(1'b1);
        state_s = FETCH;
      end else begin
        done_s = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      saved_r    <= IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      note_r     <= REST_CODE;
      cur_note_r <= REST_CODE;
      beat_r     <= {DUR_W{1'b0}};
      gap_r      <= {GAP_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      saved_r    <= saved_s;
      addr_r     <= addr_s;
      note_r     <= note_s;
      cur_note_r <= cur_note_s;
      beat_r     <= beat_s;
      gap_r      <= gap_s;
      busy_r     <= is_busy_state(state_s);
      done_r     <= done_s;
    end
  end

  assign rom_addr = addr_r;
  assign note     = note_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer (GAP_CYC=2) with a synchronous ROM model.
module tb_song_sequencer;

  localparam logic [9:0] END_WORD = {7'h7F, 3'd0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play, pause, stop;
  logic [31:0] tempo_div;
  logic [5:0]  rom_addr;
  logic [9:0]  rom_data = 10'd0;
  logic [6:0]  note;
  logic        busy, done;

  logic [9:0]  rom [0:63];
  int          tests_run = 0;
  int          tests_failed = 0;

  song_sequencer #(.GAP_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .pause(pause), .stop(stop),
    .tempo_div(tempo_div), .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [9:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; tempo_div = 32'd4;
    fill_rom(END_WORD);
    repeat (3) step();
    tests_run++;
    if ({note, busy, done, rom_addr} !== {7'd0, 1'b0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: note=%0d busy=%b done=%b addr=%0d, expected 0/0/0/0", note, busy, done, rom_addr);
    end
    reset_n = 1'b1;
    repeat (2) step();
    tests_run++;
    if ({note, busy, done, rom_addr} !== {7'd0, 1'b0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL idle_after_reset: note=%0d busy=%b done=%b addr=%0d, expected 0/0/0/0", note, busy, done, rom_addr);
    end
  endtask

  // C4 for 2 beats of 4 cycles, then end marker
  task automatic test_basic();
    logic [6:0] exp_note;
    logic       exp_busy, exp_done;
    fill_rom(END_WORD);
    rom[0] = {7'd60, 3'd1};
    tempo_div = 32'd4;
    pulse_play();
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) step();
      exp_note = (k >= 3 && k <= 10) ? 7'd60 : 7'd0;
      exp_busy = (k <= 14);
      exp_done = (k == 15);
      tests_run++;
      if ({note, busy, done} !== {exp_note, exp_busy, exp_done}) begin
        tests_failed++;
        $display("FAIL basic_cycle%0d: note=%0d busy=%b done=%b, expected note=%0d busy=%b done=%b",
                 k, note, busy, done, exp_note, exp_busy, exp_done);
      end
      if (k == 13 || k == 15) begin
        tests_run++;
        if (rom_addr !== ((k == 13) ? 6'd1 : 6'd0)) begin
          tests_failed++;
          $display("FAIL basic_addr%0d: rom_addr=%0d, expected %0d", k, rom_addr, (k == 13) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic ok;
    int   bad, remain;
    fill_rom(END_WORD);
    rom[0] = {7'd60, 3'd0};
    rom[1] = {7'd62, 3'd1};
    tempo_div = 32'd4;
    pulse_play();
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (note == 7'd62) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL pause_reach_note2: note=%0d, expected 62 within 40 cycles", note);
    end
    step(); step();
    tests_run++;
    if (note !== 7'd62) begin
      tests_failed++;
      $display("FAIL pause_note2_hold: note=%0d, expected 62", note);
    end
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (note !== 7'd0 || busy !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL pause_silent: %0d paused cycles with note!=0 or busy!=1, expected 0", bad);
    end
    pause = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    remain = 0;
    for (int i = 0; i < 20 && note == 7'd62; i++) begin
      remain++;
      step();
    end
    tests_run++;
    if (remain != 6) begin
      tests_failed++;
      $display("FAIL pause_remaining: note2 lasted %0d cycles after resume, expected 6", remain);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done === 1'b1) ok = 1'b1;
      else step();
    end
    tests_run++;
    if (!ok || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_done: done_seen=%b busy=%b, expected 1/0", ok, busy);
    end
  endtask

  task automatic test_stop();
    logic ok;
    fill_rom(END_WORD);
    for (int i = 0; i < 8; i++) rom[i] = {7'(10 + i), 3'd0};
    tempo_div = 32'd1;
    pulse_play();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (note == 7'd15) ok = 1'b1;
    end
    step();
    tests_run++;
    if (!ok || rom_addr !== 6'd5 || note !== 7'd0) begin
      tests_failed++;
      $display("FAIL stop_in_gap5: found=%b addr=%0d note=%0d, expected 1/5/0", ok, rom_addr, note);
    end
    do_stop();
    tests_run++;
    if ({rom_addr, note, busy} !== {6'd0, 7'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL stop_idle: addr=%0d note=%0d busy=%b, expected 0/0/0", rom_addr, note, busy);
    end
    pulse_play();
    step(); step();
    tests_run++;
    if (note !== 7'd10 || rom_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL stop_restart: note=%0d addr=%0d, expected 10/0", note, rom_addr);
    end
  endtask

  task automatic test_wrap();
    logic       seen;
    logic [6:0] exp_next;
    int         err, cnt;
    do_stop();
    for (int i = 0; i < 64; i++) rom[i] = {7'(i + 1), 3'd0};
    tempo_div = 32'd0;
    pulse_play();
    seen = 1'b0; err = 0; cnt = 0; exp_next = 7'd1;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (note != 7'd0) begin
        if (note !== exp_next) err++;
        exp_next = exp_next + 7'd1;
        cnt++;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || err != 0 || cnt != 64) begin
      tests_failed++;
      $display("FAIL wrap_sequence: done_seen=%b order_errors=%0d note_cycles=%0d, expected 1/0/64", seen, err, cnt);
    end
    tests_run++;
`ifdef SONG_LOOP_EN
    if (busy !== 1'b1 || rom_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL wrap_end: busy=%b addr=%0d, expected 1/0", busy, rom_addr);
    end
`else
    if (busy !== 1'b0 || rom_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL wrap_end: busy=%b addr=%0d, expected 0/0", busy, rom_addr);
    end
`endif
  endtask

  task automatic test_priority_and_reset();
    logic ok;
    do_stop();
    fill_rom(END_WORD);
    rom[0] = {7'd60, 3'd7};
    tempo_div = 32'd4;
    pulse_play();
    step(); step();
    stop = 1'b1; pause = 1'b1; play = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0; play = 1'b0;
    tests_run++;
    if ({note, busy, rom_addr} !== {7'd0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL stop_wins: note=%0d busy=%b addr=%0d, expected 0/0/0", note, busy, rom_addr);
    end
    pause = 1'b1; play = 1'b1;
    step();
    pause = 1'b0; play = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_pause_ignored: busy=%b, expected 1", busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (note == 7'd60) ok = 1'b1;
    end
    step();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || {note, busy, done, rom_addr} !== {7'd0, 1'b0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: playing=%b note=%0d busy=%b done=%b addr=%0d, expected 1/0/0/0/0",
               ok, note, busy, done, rom_addr);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

`ifdef SONG_LOOP_EN
  task automatic test_loop();
    int         err, cnt, dones, drops, idx;
    logic [6:0] exp_note;
    do_stop();
    fill_rom(END_WORD);
    rom[0] = {7'd20, 3'd0}; rom[1] = {7'd21, 3'd0}; rom[2] = {7'd22, 3'd0};
    tempo_div = 32'd1;
    pulse_play();
    err = 0; cnt = 0; dones = 0; drops = 0; idx = 0;
    for (int i = 0; i < 200 && dones < 3; i++) begin
      step();
      if (busy !== 1'b1) drops++;
      if (note != 7'd0) begin
        exp_note = 7'(20 + idx);
        if (note !== exp_note) err++;
        idx = (idx + 1) % 3;
        cnt++;
      end
      if (done === 1'b1) begin
        dones++;
        if (rom_addr !== 6'd0) err++;
      end
    end
    tests_run++;
    if (dones != 3 || cnt != 9 || err != 0 || drops != 0) begin
      tests_failed++;
      $display("FAIL loop_passes: dones=%0d notes=%0d errors=%0d busy_drops=%0d, expected 3/9/0/0", dones, cnt, err, drops);
    end
    do_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_stop();
    test_wrap();
    test_priority_and_reset();
`ifdef SONG_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
